fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and size limits for the FIFO write-side arbiter.
package fifo_arb_pkg;

    localparam int MAX_N_REQ = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_id, wrapping at N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_id,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] id
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] cand;

    // Walk from the farthest candidate back toward last_id+1 so the nearest one wins.
    always_comb begin
        found = 1'b0;
        id    = '0;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_id) + i) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling N_REQ burst sources into one async FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accepted-beat counters (beat_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter type data_t    = logic [7:0],
    parameter int  N_REQ     = 4,
    parameter int  MAX_BURST = 8
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  data_t                    req_data [N_REQ],
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output data_t                    wdata,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]              beat_cnt [N_REQ]
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > MAX_N_REQ || MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_params
        $error("fifo_wr_arbiter: N_REQ or MAX_BURST out of range");
    end

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic             in_burst;
    logic             cur_valid;
    logic             cur_last;
    logic             accept;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req     (req_valid),
        .last_id (last_id_q),
        .found   (pick_found),
        .id      (pick_id)
    );

    assign cur_valid = req_valid[grant_id_q];
    assign cur_last  = req_last[grant_id_q];
    // Reset gates the handshake directly so nothing is written while wrst is high.
    assign in_burst  = (state_q == BURST) && !wrst;
    assign accept    = in_burst && cur_valid && !wfull;

    always_comb begin
        req_ready = '0;
        if (in_burst) begin
            req_ready[grant_id_q] = !wfull;
        end
    end

    assign winc        = accept;
    assign wdata       = req_data[grant_id_q];
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_id_d     = last_id_q;
        cnt_d         = cnt_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = BURST;
                    grant_id_d    = pick_id;
                    cnt_d         = '0;
                    grant_valid_d = 1'b1;
                end
            end
            BURST: begin
                // A requester that goes quiet gives up the rest of its burst.
                if (!cur_valid) begin
                    state_d       = IDLE;
                    last_id_d     = grant_id_q;
                    grant_valid_d = 1'b0;
                end else if (!wfull) begin
                    if (cur_last || cnt_q == CNT_END) begin
                        state_d       = IDLE;
                        last_id_d     = grant_id_q;
                        grant_valid_d = 1'b0;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            last_id_q     <= ID_LAST;
            cnt_q         <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_id_q     <= last_id_d;
            cnt_q         <= cnt_d;
            grant_valid_q <= grant_valid_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] beat_cnt_q [N_REQ];
    logic [31:0] beat_cnt_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            beat_cnt_d[i] = beat_cnt_q[i];
            if (accept && grant_id_q == ID_W'(i)) begin
                beat_cnt_d[i] = beat_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        for (int i = 0; i < N_REQ; i++) begin
            beat_cnt_q[i] <= wrst ? 32'd0 : beat_cnt_d[i];
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a vector table for single-cycle FSM corners, then
// requester models feeding a per-requester scoreboard for the burst scenarios.
module tb_fifo_wr_arbiter;

    localparam int N         = 4;
    localparam int MAXB      = 8;
    localparam int SRC_DEPTH = 64;
    localparam int N_VEC     = 12;

    typedef struct {
        logic       wrst;
        logic [3:0] valid;
        logic [3:0] last;
        logic       wfull;
        logic       winc;
        logic [3:0] ready;
        logic       gv;
        logic [1:0] gid;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } sb_t;

    logic         wclk = 1'b0;
    logic         wrst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_last;
    logic [7:0]   req_data [N];
    logic [N-1:0] req_ready;
    logic         wfull;
    logic         winc;
    logic [7:0]   wdata;
    logic         grant_valid;
    logic [1:0]   grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]  beat_cnt [N];
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .data_t    (logic [7:0]),
        .N_REQ     (N),
        .MAX_BURST (MAXB)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_cnt    (beat_cnt)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    vec_t       vecs [N_VEC];
    sb_t        sb_q [$];
    int         grant_log [$];
    int         len_log [$];
    int         gap_log [$];
    logic [7:0] src_data [N][SRC_DEPTH];
    logic       src_last [N][SRC_DEPTH];
    int         src_len [N];
    int         src_pos [N];
    bit         random_gaps = 1'b0;
    logic       prev_gv     = 1'b0;
    int         burst_beats = 0;
    int         idle_cnt    = 0;
    bit         seen_burst  = 1'b0;
    logic       obs_winc;
    logic       obs_gv;
    logic [N-1:0] obs_ready;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=completion", name);
    endtask

    task automatic applyStimulus(input vec_t v);
        wrst      = v.wrst;
        req_valid = v.valid;
        req_last  = v.last;
        wfull     = v.wfull;
        for (int i = 0; i < N; i++) begin
            req_data[i] = 8'(8'hA0 + i);
        end
    endtask

    // Expected words are queued per requester in the order they are offered.
    task automatic addBeats(input int id, input int count, input bit last_at_end, input bit rand_last);
        for (int k = 0; k < count; k++) begin
            sb_t e;
            int  idx;
            idx = src_len[id];
            e.id   = id;
            e.data = 8'((id << 6) | (idx & 63));
            src_data[id][idx] = e.data;
            src_last[id][idx] = (last_at_end && k == count - 1) || (rand_last && $urandom_range(3) == 0);
            sb_q.push_back(e);
            src_len[id]++;
        end
    endtask

    function automatic bit srcPending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic driveSources();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i] = !(random_gaps && $urandom_range(7) == 0);
                req_data[i]  = src_data[i][src_pos[i]];
                req_last[i]  = src_last[i][src_pos[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'h00;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic sbPop(input int id, input logic [7:0] data);
        for (int k = 0; k < sb_q.size(); k++) begin
            if (sb_q[k].id == id) begin
                checkOutput($sformatf("sb_data_req%0d", id), data, sb_q[k].data);
                sb_q.delete(k);
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected_req%0d actual=%0h required=no_write", id, data);
    endtask

    task automatic observe();
        logic [N-1:0] hs;
        hs        = req_ready & req_valid;
        obs_winc  = winc;
        obs_gv    = grant_valid;
        obs_ready = req_ready;
        checkOutput("winc_vs_handshake", winc, |hs);
        if (!grant_valid && prev_gv) begin
            len_log.push_back(burst_beats);
            burst_beats = 0;
            seen_burst  = 1'b1;
            idle_cnt    = 0;
        end
        if (!grant_valid) idle_cnt++;
        if (grant_valid && !prev_gv) begin
            if (seen_burst) gap_log.push_back(idle_cnt);
            grant_log.push_back(int'(grant_id));
        end
        if (winc) begin
            sbPop(int'(grant_id), wdata);
            burst_beats++;
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i]) src_pos[i]++;
        end
        prev_gv = grant_valid;
    endtask

    task automatic tick();
        driveSources();
        #1;
        observe();
        @(posedge wclk);
        #1;
    endtask

    task automatic resetAll();
        wrst        = 1'b1;
        wfull       = 1'b0;
        random_gaps = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        sb_q.delete();
        tick();
        wrst = 1'b0;
        grant_log.delete();
        len_log.delete();
        gap_log.delete();
        burst_beats = 0;
        idle_cnt    = 0;
        seen_burst  = 1'b0;
        prev_gv     = grant_valid;
    endtask

    task automatic runUntilLens(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (len_log.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (len_log.size() < n) timeoutFail(name);
    endtask

    task automatic runUntilBeats(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (burst_beats < n && c < budget) begin
            tick();
            c++;
        end
        if (burst_beats < n) timeoutFail(name);
    endtask

    task automatic runUntilGrants(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (grant_log.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (grant_log.size() < n) timeoutFail(name);
    endtask

    task automatic runUntilDrained(input int budget, input bit rand_full, input string name);
        int c;
        c = 0;
        while ((srcPending() || grant_valid) && c < budget) begin
            wfull = rand_full ? ($urandom_range(3) == 0) : 1'b0;
            tick();
            c++;
        end
        wfull = 1'b0;
        if (srcPending() || grant_valid) timeoutFail(name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_wd;
        int         base;
        wrst      = 1'b1;
        wfull     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) req_data[i] = 8'h00;

        //           wrst  valid    last     wfull winc  ready    gv    gid
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[4]  = '{1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[5]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
        vecs[8]  = '{1'b1, 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[9]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[10] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};

        @(posedge wclk);
        #1;
        for (int r = 0; r < N_VEC; r++) begin
            applyStimulus(vecs[r]);
            #1;
            exp_wd = 8'(8'hA0 + vecs[r].gid);
            checkOutput($sformatf("vec%0d_winc", r), winc, vecs[r].winc);
            checkOutput($sformatf("vec%0d_ready", r), req_ready, vecs[r].ready);
            checkOutput($sformatf("vec%0d_grant_valid", r), grant_valid, vecs[r].gv);
            checkOutput($sformatf("vec%0d_grant_id", r), grant_id, vecs[r].gid);
            checkOutput($sformatf("vec%0d_wdata", r), wdata, exp_wd);
            @(posedge wclk);
            #1;
        end

        $display("[TB] all requesters saturated, no last");
        resetAll();
        for (int i = 0; i < N; i++) addBeats(i, 16, 1'b0, 1'b0);
        runUntilLens(5, 200, "s1_bursts");
        checkOutput("s1_nbursts", len_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) checkOutput($sformatf("s1_grant%0d", k), grant_log[k], k % N);
            if (k < len_log.size()) checkOutput($sformatf("s1_len%0d", k), len_log[k], MAXB);
            if (k < 4 && k < gap_log.size()) checkOutput($sformatf("s1_gap%0d", k), gap_log[k], 1);
        end

        $display("[TB] short burst with last");
        resetAll();
        addBeats(2, 3, 1'b1, 1'b0);
        runUntilLens(1, 50, "s2_burst");
        if (grant_log.size() > 0) checkOutput("s2_grant", grant_log[0], 2);
        if (len_log.size() > 0) checkOutput("s2_len", len_log[0], 3);
        checkOutput("s2_idle_after", grant_valid, 0);
        addBeats(1, 1, 1'b1, 1'b0);
        addBeats(3, 1, 1'b1, 1'b0);
        runUntilLens(3, 50, "s2_followers");
        if (grant_log.size() > 2) begin
            checkOutput("s2_next_after_2", grant_log[1], 3);
            checkOutput("s2_then", grant_log[2], 1);
        end

        $display("[TB] full stall mid-burst");
        resetAll();
        addBeats(0, 10, 1'b0, 1'b0);
        runUntilBeats(4, 50, "s3_first_beats");
        wfull = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput($sformatf("s3_stall%0d_winc", s), obs_winc, 0);
            checkOutput($sformatf("s3_stall%0d_gv", s), obs_gv, 1);
            checkOutput($sformatf("s3_stall%0d_ready", s), obs_ready, 0);
        end
        wfull = 1'b0;
        runUntilLens(2, 60, "s3_resume");
        if (len_log.size() > 1) begin
            checkOutput("s3_len_total", len_log[0], MAXB);
            checkOutput("s3_regrant_id", grant_log[1], 0);
            checkOutput("s3_regrant_gap", gap_log[0], 1);
            checkOutput("s3_tail_len", len_log[1], 2);
        end

        $display("[TB] requester drops valid");
        resetAll();
        addBeats(1, 2, 1'b0, 1'b0);
        addBeats(3, 2, 1'b1, 1'b0);
        runUntilLens(2, 50, "s4_bursts");
        if (len_log.size() > 1) begin
            checkOutput("s4_first_grant", grant_log[0], 1);
            checkOutput("s4_first_len", len_log[0], 2);
            checkOutput("s4_pending_grant", grant_log[1], 3);
            checkOutput("s4_pending_len", len_log[1], 2);
        end

        $display("[TB] reset mid-burst");
        resetAll();
        addBeats(0, 1, 1'b1, 1'b0);
        runUntilLens(1, 30, "s5_prime");
        addBeats(0, 10, 1'b0, 1'b0);
        runUntilBeats(4, 50, "s5_four_beats");
        addBeats(1, 3, 1'b1, 1'b0);
        wrst = 1'b1;
        tick();
        checkOutput("s5_rst_winc", obs_winc, 0);
        checkOutput("s5_rst_ready", obs_ready, 0);
        wrst = 1'b0;
        checkOutput("s5_gv_after_rst", grant_valid, 0);
        checkOutput("s5_gid_after_rst", grant_id, 0);
        base = grant_log.size();
        runUntilGrants(base + 1, 20, "s5_regrant");
        if (grant_log.size() > base) checkOutput("s5_regrant_id", grant_log[base], 0);
        runUntilDrained(200, 1'b0, "s5_drain");
        checkOutput("s5_sb_empty", sb_q.size(), 0);

        $display("[TB] random traffic drain");
        resetAll();
        random_gaps = 1'b1;
        for (int i = 0; i < N; i++) addBeats(i, $urandom_range(30, 10), 1'b1, 1'b1);
        runUntilDrained(3000, 1'b1, "s6_drain");
        random_gaps = 1'b0;
        checkOutput("s6_sb_empty", sb_q.size(), 0);
        for (int k = 0; k < len_log.size(); k++) begin
            checkOutput($sformatf("s6_len%0d_le_max", k), len_log[k] <= MAXB, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
